// File: rtl/vga_pkg.sv
// Shared display constants and the VRAM arbiter state encoding.
// Lives alongside the VGA timing block and the arbiter.
package vga_pkg;

  localparam int NLINES = 480;
  localparam int LINE_W = 640;
  localparam int AW     = 9;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 29;
  localparam int V_TOTAL   = 521;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FETCH      = 2'd1,
    ST_FETCH_WAIT = 2'd2,
    ST_CLEAR      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Single-port line VRAM bus.
// master = arbiter side, slave = RAM side.
interface vram_arbiter_if #(
  parameter int AW     = 9,
  parameter int LINE_W = 640
);

  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [LINE_W-1:0] ram_wdata;
  logic [LINE_W-1:0] ram_rdata;

  modport master (
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/vram_clear_seq.sv
// Clear sweep sequencer: address counter, busy/done,
// and the pause/resume bookkeeping around fetches.
module vram_clear_seq #(
  parameter int NLINES = vga_pkg::NLINES,
  parameter int AW     = vga_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic          i_resume,
  input  logic          i_step,
  output logic          o_pend,
  output logic          o_resume,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic          r_pend;
  logic          r_resume;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_addr;
  logic          w_accept;

  assign w_accept = i_req && !r_busy;
  assign o_last   = 32'(r_addr) == NLINES - 1;
  assign o_pend   = r_pend;
  assign o_resume = r_resume;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_addr   = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= 1'b0;
      r_resume <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_pend <= 1'b1;
        r_busy <= 1'b1;
        r_addr <= '0;
      end
      if (i_start)
        r_pend <= 1'b0;
      if (i_pause)
        r_resume <= 1'b1;
      else if (i_resume)
        r_resume <= 1'b0;
      if (i_step) begin
        r_addr <= r_addr + 1'b1;
        if (o_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: scanout prefetch > clear sweep > writer,
// one access per cycle, registered line buffer out.
module vram_arbiter #(
  parameter int NLINES = vga_pkg::NLINES,
  parameter int LINE_W = vga_pkg::LINE_W,
  parameter int AW     = vga_pkg::AW
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [AW-1:0]     fetch_ln,
  output logic [LINE_W-1:0] line_out,
  output logic              line_rdy,
  output logic              fetch_overrun,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  vram_arbiter_if.master    ram
);

  import vga_pkg::*;

  arb_state_e        r_state;
  arb_state_e        w_nxt;
  logic              r_fetch_pend;
  logic [AW-1:0]     r_fetch_ln;
  logic              r_fetch_vld;
  logic              r_overrun;
  logic [LINE_W-1:0] r_line;
  logic              r_rdy;

  logic              w_fetch;
  logic              w_fln_ok;
  logic              w_wr_ok;
  logic              w_start;
  logic              w_pause;
  logic              w_resume;
  logic              w_step;
  logic              w_clr_pend;
  logic              w_resume_clr;
  logic [AW-1:0]     w_clr_addr;
  logic              w_clr_last;
  logic              w_en;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [LINE_W-1:0] w_wdata;
  logic              w_ack;

  assign w_fetch  = fetch_req || r_fetch_pend;
  assign w_fln_ok = 32'(r_fetch_ln) < NLINES;
  assign w_wr_ok  = 32'(wr_addr) < NLINES;

  vram_clear_seq #(
    .NLINES (NLINES),
    .AW     (AW)
  ) u_clr (
    .clk      (dclk),
    .rst      (rst),
    .i_req    (clr_req),
    .i_start  (w_start),
    .i_pause  (w_pause),
    .i_resume (w_resume),
    .i_step   (w_step),
    .o_pend   (w_clr_pend),
    .o_resume (w_resume_clr),
    .o_busy   (clr_busy),
    .o_done   (clr_done),
    .o_addr   (w_clr_addr),
    .o_last   (w_clr_last)
  );

  always_comb begin
    w_nxt    = r_state;
    w_en     = 1'b0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    w_ack    = 1'b0;
    w_start  = 1'b0;
    w_pause  = 1'b0;
    w_resume = 1'b0;
    w_step   = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_fetch) begin
            w_nxt = ST_FETCH;
          end else if (w_clr_pend) begin
            w_nxt   = ST_CLEAR;
            w_start = 1'b1;
          end else if (wr_req && !clr_busy) begin
            w_ack = 1'b1;
            // out-of-range writes are acked but dropped
            if (w_wr_ok) begin
              w_en    = 1'b1;
              w_we    = 1'b1;
              w_addr  = wr_addr;
              w_wdata = wr_data;
            end
          end
        end
        ST_FETCH: begin
          w_en   = w_fln_ok;
          w_addr = r_fetch_ln;
          w_nxt  = ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          w_resume = w_resume_clr;
          w_nxt    = w_resume_clr ? ST_CLEAR : ST_IDLE;
        end
        ST_CLEAR: begin
          if (w_fetch) begin
            w_pause = 1'b1;
            w_nxt   = ST_FETCH;
          end else begin
            w_en   = 1'b1;
            w_we   = 1'b1;
            w_addr = w_clr_addr;
            w_step = 1'b1;
            if (w_clr_last)
              w_nxt = ST_IDLE;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fetch_pend <= 1'b0;
      r_fetch_ln   <= '0;
      r_fetch_vld  <= 1'b0;
      r_overrun    <= 1'b0;
      r_line       <= '0;
      r_rdy        <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rdy   <= 1'b0;
      if (fetch_req) begin
        r_fetch_ln <= fetch_ln;
        if (r_fetch_pend)
          r_overrun <= 1'b1;
      end
      if (w_nxt == ST_FETCH)
        r_fetch_pend <= 1'b0;
      else if (fetch_req)
        r_fetch_pend <= 1'b1;
      // fetch_ln_q may be overwritten before the data returns
      if (r_state == ST_FETCH)
        r_fetch_vld <= w_fln_ok;
      if (r_state == ST_FETCH_WAIT) begin
        r_line <= r_fetch_vld ? ram.ram_rdata : '0;
        r_rdy  <= 1'b1;
      end
    end
  end

  assign ram.ram_en    = w_en;
  assign ram.ram_we    = w_we;
  assign ram.ram_addr  = w_addr;
  assign ram.ram_wdata = w_wdata;

  assign line_out      = r_line;
  assign line_rdy      = r_rdy;
  assign fetch_overrun = r_overrun;
  assign wr_ack        = w_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed/randomised bench for vram_arbiter with a
// line-array reference model of VRAM contents.
module tb_vram_arbiter;

  import vga_pkg::*;

  localparam int NL = NLINES;
  localparam int LW = LINE_W;

  logic          dclk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_ln;
  logic [LW-1:0] line_out;
  logic          line_rdy;
  logic          fetch_overrun;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  logic          wr_ack;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  vram_arbiter_if #(.AW(AW), .LINE_W(LW)) bus ();

  vram_arbiter dut (
    .dclk          (dclk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_ln      (fetch_ln),
    .line_out      (line_out),
    .line_rdy      (line_rdy),
    .fetch_overrun (fetch_overrun),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .clr_req       (clr_req),
    .clr_busy      (clr_busy),
    .clr_done      (clr_done),
    .ram           (bus)
  );

  always #5 dclk = ~dclk;

  int unsigned   seed;
  logic          do_init = 1'b0;
  logic [LW-1:0] vmem  [NL];
  logic [LW-1:0] model [NL];
  int            n_chk = 0;
  int            n_err = 0;

  function automatic logic [LW-1:0] init_line(input int i);
    logic [LW-1:0] r;
    for (int w = 0; w < LW / 32; w++)
      r[w*32 +: 32] = seed ^ (32'(i + 1) * 32'h9E3779B1)
                    ^ (32'(w + 7) * 32'h85EBCA6B);
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int w = 0; w < LW / 32; w++)
      r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural single-port VRAM: read data one cycle later
  always @(posedge dclk) begin
    if (do_init) begin
      for (int i = 0; i < NL; i++)
        vmem[i] <= init_line(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we)
        vmem[bus.ram_addr] <= bus.ram_wdata;
      else
        bus.ram_rdata <= vmem[bus.ram_addr];
    end
  end

  task automatic cyc();
    @(posedge dclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0b want=%0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs,
                      input logic [AW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [LW-1:0] obs,
                      input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Fetch from IDLE: read at +1, line_out/line_rdy at +3 only
  task automatic fetch_chk(input int ln, input string tag);
    logic [LW-1:0] e;
    e = '0;
    if (ln < NL)
      e = model[ln];
    fetch_req = 1'b1;
    fetch_ln  = AW'(ln);
    settle();
    chk1({tag, ".c0_en"}, bus.ram_en, 1'b0);
    cyc();
    fetch_req = 1'b0;
    settle();
    chk1({tag, ".c1_en"}, bus.ram_en, ln < NL);
    chk1({tag, ".c1_we"}, bus.ram_we, 1'b0);
    if (ln < NL)
      chka({tag, ".c1_addr"}, bus.ram_addr, AW'(ln));
    cyc();
    settle();
    chk1({tag, ".c2_rdy"}, line_rdy, 1'b0);
    chk1({tag, ".c2_en"}, bus.ram_en, 1'b0);
    cyc();
    settle();
    chk1({tag, ".c3_rdy"}, line_rdy, 1'b1);
    chkw({tag, ".c3_line"}, line_out, e);
    cyc();
    settle();
    chk1({tag, ".c4_rdy"}, line_rdy, 1'b0);
  endtask

  task automatic do_write(input int a, input logic [LW-1:0] d,
                          input string tag);
    logic got;
    got     = 1'b0;
    wr_req  = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    for (int k = 0; k < 40 && !got; k++) begin
      settle();
      if (wr_ack === 1'b1)
        got = 1'b1;
      else
        cyc();
    end
    chk1({tag, ".ack"}, got, 1'b1);
    chk1({tag, ".en"}, bus.ram_en, a < NL);
    if (a < NL) begin
      chka({tag, ".addr"}, bus.ram_addr, AW'(a));
      chkw({tag, ".wdata"}, bus.ram_wdata, d);
      model[a] = d;
    end
    cyc();
    wr_req = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] b, old5, c_data, d300, e7, rd_line;
    int            wa [6];
    int            t, t0, td, ea, ord_bad, ack_bad, rdy_n, k;
    int            n_done, n_en;
    logic          fired, hit;

    rst       = 1'b1;
    fetch_req = 1'b0;
    fetch_ln  = '0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clr_req   = 1'b0;
    seed      = $urandom;
    for (int i = 0; i < NL; i++)
      model[i] = init_line(i);
    do_init = 1'b1;
    cyc();
    do_init = 1'b0;
    cyc();
    cyc();
    settle();

    chkw("rst.line_out", line_out, '0);
    chk1("rst.line_rdy", line_rdy, 1'b0);
    chk1("rst.overrun", fetch_overrun, 1'b0);
    chk1("rst.clr_busy", clr_busy, 1'b0);
    chk1("rst.clr_done", clr_done, 1'b0);
    chk1("rst.wr_ack", wr_ack, 1'b0);
    chk1("rst.ram_en", bus.ram_en, 1'b0);
    chk1("rst.ram_we", bus.ram_we, 1'b0);
    chka("rst.ram_addr", bus.ram_addr, '0);
    chkw("rst.ram_wdata", bus.ram_wdata, '0);
    rst = 1'b0;
    cyc();

    fetch_chk(10, "fetch10");

    // Write and fetch of the same line in one cycle
    b    = rnd_line();
    old5 = model[5];
    wr_req    = 1'b1;
    wr_addr   = AW'(5);
    wr_data   = b;
    fetch_req = 1'b1;
    fetch_ln  = AW'(5);
    settle();
    chk1("col.c0_ack", wr_ack, 1'b0);
    chk1("col.c0_en", bus.ram_en, 1'b0);
    cyc();
    fetch_req = 1'b0;
    settle();
    chk1("col.c1_ack", wr_ack, 1'b0);
    chk1("col.c1_we", bus.ram_we, 1'b0);
    chka("col.c1_addr", bus.ram_addr, AW'(5));
    cyc();
    settle();
    chk1("col.c2_ack", wr_ack, 1'b0);
    cyc();
    settle();
    chk1("col.c3_rdy", line_rdy, 1'b1);
    chkw("col.c3_line", line_out, old5);
    chk1("col.c3_ack", wr_ack, 1'b1);
    chk1("col.c3_we", bus.ram_we, 1'b1);
    chkw("col.c3_wdata", bus.ram_wdata, b);
    cyc();
    wr_req   = 1'b0;
    model[5] = b;
    fetch_chk(5, "col.refetch");

    wa[0] = 0;
    wa[1] = NL - 1;
    for (int i = 2; i < 6; i++)
      wa[i] = int'($urandom_range(NL - 1));
    for (int i = 0; i < 6; i++) begin
      do_write(wa[i], rnd_line(), $sformatf("wr%0d", i));
      fetch_chk(wa[i], $sformatf("rd%0d", i));
    end

    fetch_chk(NL, "oob_fetch");
    do_write(500, rnd_line(), "oob_wr");

    // Three back-to-back fetches: the last one wins
    fetch_req = 1'b1;
    fetch_ln  = AW'(20);
    settle();
    chk1("ov.c0", fetch_overrun, 1'b0);
    cyc();
    fetch_ln = AW'(30);
    settle();
    chka("ov.c1_addr", bus.ram_addr, AW'(20));
    cyc();
    fetch_ln = AW'(40);
    settle();
    chk1("ov.c2", fetch_overrun, 1'b0);
    cyc();
    fetch_req = 1'b0;
    settle();
    chk1("ov.c3_flag", fetch_overrun, 1'b1);
    chk1("ov.c3_rdy", line_rdy, 1'b1);
    chkw("ov.c3_line", line_out, model[20]);
    cyc();
    settle();
    chk1("ov.c4_en", bus.ram_en, 1'b1);
    chka("ov.c4_addr", bus.ram_addr, AW'(40));
    cyc();
    cyc();
    settle();
    chk1("ov.c6_rdy", line_rdy, 1'b1);
    chkw("ov.c6_line", line_out, model[40]);
    cyc();

    // Clear sweep with one interleaved fetch and a stalled write
    clr_req = 1'b1;
    settle();
    chk1("clr.c0_busy", clr_busy, 1'b0);
    cyc();
    clr_req = 1'b0;
    c_data  = rnd_line();
    wr_req  = 1'b1;
    wr_addr = AW'(7);
    wr_data = c_data;
    settle();
    chk1("clr.c1_busy", clr_busy, 1'b1);
    t = 1; t0 = -1; td = -1; ea = 0;
    ord_bad = 0; ack_bad = 0; rdy_n = 0;
    fired = 1'b0;
    rd_line = '0;
    while (td < 0 && t < 1000) begin
      if (wr_ack && !clr_done)
        ack_bad++;
      if (bus.ram_en && bus.ram_we && clr_busy) begin
        if (t0 < 0)
          t0 = t;
        if (bus.ram_addr != AW'(ea) || bus.ram_wdata != '0)
          ord_bad++;
        ea++;
      end
      if (line_rdy) begin
        rdy_n++;
        rd_line = line_out;
      end
      if (clr_done) begin
        td = t;
      end else begin
        cyc();
        t++;
        fetch_req = (ea == 50) && !fired;
        if (fetch_req) begin
          fired    = 1'b1;
          fetch_ln = AW'(100);
        end
        settle();
        if (fetch_req)
          chk1("clr.pause_en", bus.ram_en, 1'b0);
      end
    end
    chk1("clr.done_seen", td >= 0, 1'b1);
    chki("clr.len", td - t0, NL + 3);
    chki("clr.order_bad", ord_bad, 0);
    chki("clr.writes", ea, NL);
    chki("clr.ack_stall", ack_bad, 0);
    chki("clr.rdy_n", rdy_n, 1);
    chkw("clr.line100", rd_line, model[100]);
    chk1("clr.busy_low", clr_busy, 1'b0);
    chk1("clr.wr_ack", wr_ack, 1'b1);
    chka("clr.wr_addr", bus.ram_addr, AW'(7));
    for (int i = 0; i < NL; i++)
      model[i] = '0;
    model[7] = c_data;
    cyc();
    wr_req = 1'b0;
    settle();
    chk1("clr.done_pulse", clr_done, 1'b0);
    for (int i = 0; i < NL; i++)
      fetch_chk(i, $sformatf("sweep%0d", i));

    // Reset in the middle of a sweep
    d300 = rnd_line();
    e7   = rnd_line();
    do_write(300, d300, "pre.wr300");
    do_write(7, e7, "pre.wr7");
    fetch_chk(7, "pre.rd7");
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    hit = 1'b0;
    k   = 0;
    while (!hit && k < 600) begin
      settle();
      if (bus.ram_en && bus.ram_we && bus.ram_addr == AW'(199))
        hit = 1'b1;
      cyc();
      k++;
    end
    chk1("rst2.reach", hit, 1'b1);
    rst = 1'b1;
    cyc();
    settle();
    chkw("rst2.line_out", line_out, '0);
    chk1("rst2.line_rdy", line_rdy, 1'b0);
    chk1("rst2.overrun", fetch_overrun, 1'b0);
    chk1("rst2.clr_busy", clr_busy, 1'b0);
    chk1("rst2.clr_done", clr_done, 1'b0);
    chk1("rst2.ram_en", bus.ram_en, 1'b0);
    chka("rst2.ram_addr", bus.ram_addr, '0);
    rst = 1'b0;
    n_done = 0;
    n_en   = 0;
    for (int i = 0; i < 600; i++) begin
      cyc();
      settle();
      if (clr_done)
        n_done++;
      if (bus.ram_en)
        n_en++;
    end
    chki("rst2.no_done", n_done, 0);
    chki("rst2.no_access", n_en, 0);
    for (int i = 0; i < 200; i++)
      model[i] = '0;
    fetch_chk(7, "post.rd7");
    fetch_chk(199, "post.rd199");
    fetch_chk(300, "post.rd300");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
